soc_debug_ctrl: RTL and testbench
=================================

# soc_debug_ctrl

Multi-core debug/control slave between the Zynq PS AXI4-Lite master and one or more rv32i cores. It provides a CSR bank (per-core halt, core select, status, fault mask) and word access to the selected core's register file. The regfile access includes byte-strobe read-modify-write and a configurable halt-settle interval. It replaces the single-core control module; the cores' regfiles remain clocked while their `cm_cpu_stop` is high.

## Interface
Parameters:
- `NUM_CORES`, 1 — number of cores; 1..8.
- `DATA_WIDTH`, 32 — regfile and AXI data width; the strobe width is `DATA_WIDTH/8`.
- `REG_ADDR_WIDTH`, 5 — regfile index width.
- `AXI_ADDR_WIDTH`, 8 — byte address width; must equal `REG_ADDR_WIDTH+3`.
- `STOP_SETTLE`, 2 — cycles between auto-halt assertion and the regfile access; at least 1.

Ports:
- `clk` in 1 — clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `cm_cpu_stop` out `NUM_CORES` — per-core stall.
- `cm_regfile_we` out `NUM_CORES` — per-core regfile write enable, one-cycle pulse.
- `cm_regfile_addr` out `REG_ADDR_WIDTH` — shared regfile index.
- `cm_write_regfile_dat` out `DATA_WIDTH` — merged write data.
- `cm_read_regfile_dat` in `NUM_CORES*DATA_WIDTH` — core k occupies slice `[k*DATA_WIDTH +: DATA_WIDTH]`; combinational read.
- `S_AXI_AW{VALID,READY,ADDR,PROT}`, `S_AXI_W{VALID,READY,DATA,STRB}`, `S_AXI_B{VALID,READY,RESP}`, `S_AXI_AR{VALID,READY,ADDR,PROT}`, `S_AXI_R{VALID,READY,DATA,RESP}` — standard AXI4-Lite slave; PROT is ignored.
- `deb_state` out 3 — FSM state encoding.

## Operation
Address map (byte address, bits [1:0] ignored):
- 0x00 HALT: RW, bits `[NUM_CORES-1:0]` are sticky halt requests.
- 0x04 CORE_SEL: RW, bits [2:0].
- 0x08 STATUS: RO, returns `cm_cpu_stop`; writes are ignored and respond OKAY.
- 0x0C FAULT_MASK: RW.
- Other addresses below bit `REG_ADDR_WIDTH+2`: unmapped; respond SLVERR, no side effects, reads return 0.
- Address bit `REG_ADDR_WIDTH+2` set: regfile region, index = `ADDR[REG_ADDR_WIDTH+1:2]`, target core = CORE_SEL.
- If CORE_SEL ≥ `NUM_CORES`, regfile accesses respond SLVERR, with no halt and no write.

Transaction acceptance:
- One transaction at a time.
- A write is accepted only when AWVALID and WVALID are both high. AWREADY and WREADY then pulse together for one cycle, and AWADDR/WDATA/WSTRB are latched.
- A read pulses ARREADY for one cycle and latches ARADDR.
- If a read and a write are both eligible in IDLE, the one not served last wins. After reset, the read wins.

FSM states: IDLE, HALT_WAIT, RF_READ, RF_WRITE, RESP.
- CSR access: IDLE→RESP. A CSR write updates the register at the acceptance edge.
- Regfile access with the target core not stopped: IDLE→HALT_WAIT. The auto-halt bit is set and `cm_cpu_stop[k]` rises; the state is held for `STOP_SETTLE` cycles, then →RF_READ.
- Regfile access with the target core already stopped: IDLE→RF_READ.
- RF_READ: `cm_regfile_addr` = index.
  - Read: capture RDATA, →RESP.
  - Write: merge WDATA on strobed bytes with read data on unstrobed bytes, →RF_WRITE.
- RF_WRITE: `cm_regfile_we[k]`=1 for one cycle, →RESP.
- RESP: RVALID or BVALID held until RREADY or BREADY. On the handshake edge, →IDLE and the auto-halt bit clears.

Core stall and read-back:
- `cm_cpu_stop[k]` = `HALT[k] | auto_halt[k]`.
- RDATA and RRESP hold stable while RVALID is high.
- `cm_regfile_addr` is 0 outside RF_READ and RF_WRITE.

## Timing
Reset values:
- All READY, VALID, `cm_cpu_stop`, `cm_regfile_we`, and HALT/CORE_SEL/FAULT_MASK registers are 0.
- RESP = OKAY; RDATA = 0; state IDLE.
- The regfile contents are untouched.

Latency, acceptance edge to VALID high:
- CSR: 1 cycle.
- Regfile read: 2 cycles if halted, `STOP_SETTLE+2` if auto-halt.
- Regfile write: 3 cycles if halted, `STOP_SETTLE+3` if auto-halt.

Boundary conditions:
- Auto-halt `cm_cpu_stop` falls on the edge after the R or B handshake, unless HALT[k] is set.
- A HALT write clearing bit k while an auto-halt is active for k does not release the core until the response completes.
- `rst_n` low mid-transaction returns to IDLE immediately: VALIDs drop, stop deasserts, and no write pulse is issued.
- AWVALID high without WVALID blocks nothing; reads may proceed.

## Configuration
- `SOC_CTRL_FAULT_INJ_EN` defined:
  - In RF_WRITE, the written data is merged data XOR FAULT_MASK.
  - FAULT_MASK auto-clears to 0 on that same edge (one-shot).
  - The mask is not applied to reads.
- Undefined: FAULT_MASK reads 0, writes to it respond OKAY and are ignored, and no XOR is applied.

## Structure
- Package `soc_ctrl_pkg`: FSM state encoding, CSR offsets, OKAY/SLVERR codes, and the CORE_SEL field width.
- Sub-module `soc_ctrl_csr`: HALT, CORE_SEL, and FAULT_MASK registers, address decode, and the read mux.
- The top level holds the FSM, arbitration, settle counter, and byte merge.

## Test plan
- Core running, read 0x88 (x2 = 0x1234_5678), `STOP_SETTLE`=2 → stop rises at the acceptance edge; RVALID 4 cycles later with 0x1234_5678, OKAY; stop falls after the R handshake.
- x5 = 0xAABB_CCDD, write 0x94 WDATA 0x1122_3344 STRB 0b0101 → one `we` pulse, x5 = 0xAA22_CC44, BRESP OKAY.
- HALT=0x1, then regfile read → no HALT_WAIT, RVALID 2 cycles after acceptance, stop stays high afterwards; HALT=0 releases it.
- FAULT_MASK=0x1, write 0x0 to x3 (with fault macro) → x3 = 0x1, FAULT_MASK reads 0; second write 0x0 → x3 = 0x0.
- AR (to 0x88) and AW+W (to 0x8C) valid in the same cycle after reset → read served first, then the write; CORE_SEL=`NUM_CORES` → SLVERR, no stop.
- `rst_n` asserted during HALT_WAIT of a write → all outputs reset, no `we` pulse, regfile unchanged.

Source files
------------

// File: rtl/soc_ctrl_pkg.sv
// Shared types and constants for the multi-core debug/control slave.
package soc_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StHaltWait = 3'd1,
        StRfRead   = 3'd2,
        StRfWrite  = 3'd3,
        StResp     = 3'd4
    } deb_state_e;

    // CSR offsets expressed as word index (byte offset >> 2)
    localparam logic [1:0] CsrHalt      = 2'd0;
    localparam logic [1:0] CsrCoreSel   = 2'd1;
    localparam logic [1:0] CsrStatus    = 2'd2;
    localparam logic [1:0] CsrFaultMask = 2'd3;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    localparam int unsigned CoreSelW = 3;

endpackage

// File: rtl/soc_ctrl_csr.sv
// CSR bank: HALT, CORE_SEL, FAULT_MASK registers, decode and read mux.
// FAULT_MASK is only implemented when SOC_CTRL_FAULT_INJ_EN is defined.
module soc_ctrl_csr
    import soc_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CORES      = 1,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] word_idx,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      fault_clr,
    input  logic [NUM_CORES-1:0]      cpu_stop,
    output logic                      hit,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic [NUM_CORES-1:0]      halt,
    output logic [CoreSelW-1:0]       core_sel,
    output logic [DATA_WIDTH-1:0]     fault_mask
);

    logic [1:0]           off;
    logic [NUM_CORES-1:0] halt_q, halt_d;
    logic [CoreSelW-1:0]  core_sel_q, core_sel_d;

    assign off      = word_idx[1:0];
    assign hit      = (word_idx[REG_ADDR_WIDTH-1:2] == '0);
    assign halt     = halt_q;
    assign core_sel = core_sel_q;

    always_comb begin
        halt_d     = halt_q;
        core_sel_d = core_sel_q;
        if (wr_en && hit) begin
            if (off == CsrHalt)    halt_d     = wr_data[NUM_CORES-1:0];
            if (off == CsrCoreSel) core_sel_d = wr_data[CoreSelW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q     <= '0;
            core_sel_q <= '0;
        end else begin
            halt_q     <= halt_d;
            core_sel_q <= core_sel_d;
        end
    end

`ifdef SOC_CTRL_FAULT_INJ_EN
    logic [DATA_WIDTH-1:0] fault_q, fault_d;

    // One-shot: the injecting regfile write clears the mask
    always_comb begin
        fault_d = fault_q;
        if (wr_en && hit && off == CsrFaultMask) fault_d = wr_data;
        if (fault_clr) fault_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= '0;
        else        fault_q <= fault_d;
    end

    assign fault_mask = fault_q;
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
    assign fault_mask       = '0;
`endif

    logic unused_wr_data;
    assign unused_wr_data = ^wr_data;

    always_comb begin
        rd_data = '0;
        if (hit) begin
            unique case (off)
                CsrHalt:      rd_data[NUM_CORES-1:0] = halt_q;
                CsrCoreSel:   rd_data[CoreSelW-1:0]  = core_sel_q;
                CsrStatus:    rd_data[NUM_CORES-1:0] = cpu_stop;
                CsrFaultMask: rd_data                = fault_mask;
            endcase
        end
    end

endmodule

// File: rtl/soc_debug_ctrl.sv
// AXI4-Lite debug/control slave for rv32i cores: CSR bank plus halted regfile RMW access.
// Optional fault injection on regfile writes via SOC_CTRL_FAULT_INJ_EN.
module soc_debug_ctrl
    import soc_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CORES      = 1,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned AXI_ADDR_WIDTH = 8,
    parameter int unsigned STOP_SETTLE    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    output logic [NUM_CORES-1:0]            cm_cpu_stop,
    output logic [NUM_CORES-1:0]            cm_regfile_we,
    output logic [REG_ADDR_WIDTH-1:0]       cm_regfile_addr,
    output logic [DATA_WIDTH-1:0]           cm_write_regfile_dat,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] cm_read_regfile_dat,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    input  logic [DATA_WIDTH-1:0]           S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    output logic [1:0]                      S_AXI_BRESP,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [DATA_WIDTH-1:0]           S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic [2:0]                      deb_state
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned CntW  = (STOP_SETTLE > 1) ? $clog2(STOP_SETTLE) : 1;
    localparam logic [CntW-1:0] SettleLoad = CntW'(STOP_SETTLE - 1);

    deb_state_e                state_q, state_d;
    logic                      is_write_q, is_write_d;
    logic                      prefer_wr_q, prefer_wr_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [StrbW-1:0]          wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]     merged_q, merged_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                resp_q, resp_d;
    logic [NUM_CORES-1:0]      auto_halt_q, auto_halt_d;
    logic [CntW-1:0]           settle_q, settle_d;

    logic                      grant_rd, grant_wr, csr_wr_en, fault_clr, csr_hit;
    logic [AXI_ADDR_WIDTH-1:0] acc_addr;
    logic [NUM_CORES-1:0]      halt, sel_onehot;
    logic [CoreSelW-1:0]       core_sel;
    logic [DATA_WIDTH-1:0]     csr_rdata, fault_mask, rd_word;
    logic [REG_ADDR_WIDTH-1:0] rf_idx;

    // Round-robin between read and write; read wins out of reset
    assign grant_rd = S_AXI_ARVALID && !(S_AXI_AWVALID && S_AXI_WVALID && prefer_wr_q);
    assign grant_wr = S_AXI_AWVALID && S_AXI_WVALID && !grant_rd;
    assign acc_addr = grant_rd ? S_AXI_ARADDR : S_AXI_AWADDR;
    assign rf_idx   = addr_q[REG_ADDR_WIDTH+1:2];

    always_comb begin
        sel_onehot = '0;
        rd_word    = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (core_sel == CoreSelW'(k)) begin
                sel_onehot[k] = 1'b1;
                rd_word       = cm_read_regfile_dat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    soc_ctrl_csr #(
        .NUM_CORES      (NUM_CORES),
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_csr (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_idx   (acc_addr[REG_ADDR_WIDTH+1:2]),
        .wr_en      (csr_wr_en),
        .wr_data    (S_AXI_WDATA),
        .fault_clr  (fault_clr),
        .cpu_stop   (cm_cpu_stop),
        .hit        (csr_hit),
        .rd_data    (csr_rdata),
        .halt       (halt),
        .core_sel   (core_sel),
        .fault_mask (fault_mask)
    );

    always_comb begin
        state_d         = state_q;
        is_write_d      = is_write_q;
        prefer_wr_d     = prefer_wr_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        merged_d        = merged_q;
        rdata_d         = rdata_q;
        resp_d          = resp_q;
        auto_halt_d     = auto_halt_q;
        settle_d        = settle_q;
        S_AXI_ARREADY   = 1'b0;
        S_AXI_AWREADY   = 1'b0;
        S_AXI_WREADY    = 1'b0;
        csr_wr_en       = 1'b0;
        fault_clr       = 1'b0;
        cm_regfile_we   = '0;
        cm_regfile_addr = '0;

        unique case (state_q)
            StIdle: begin
                if (grant_rd || grant_wr) begin
                    S_AXI_ARREADY = grant_rd;
                    S_AXI_AWREADY = grant_wr;
                    S_AXI_WREADY  = grant_wr;
                    is_write_d    = grant_wr;
                    prefer_wr_d   = grant_rd;
                    addr_d        = acc_addr;
                    wdata_d       = S_AXI_WDATA;
                    wstrb_d       = S_AXI_WSTRB;
                    if (!acc_addr[REG_ADDR_WIDTH+2]) begin
                        csr_wr_en = grant_wr;
                        resp_d    = csr_hit ? RespOkay : RespSlverr;
                        if (grant_rd) rdata_d = csr_rdata;
                        state_d   = StResp;
                    end else if (sel_onehot == '0) begin
                        resp_d  = RespSlverr;
                        if (grant_rd) rdata_d = '0;
                        state_d = StResp;
                    end else if ((cm_cpu_stop & sel_onehot) != '0) begin
                        state_d = StRfRead;
                    end else begin
                        auto_halt_d = sel_onehot;
                        settle_d    = SettleLoad;
                        state_d     = StHaltWait;
                    end
                end
            end
            StHaltWait: begin
                if (settle_q == '0) state_d  = StRfRead;
                else                settle_d = settle_q - 1'b1;
            end
            StRfRead: begin
                cm_regfile_addr = rf_idx;
                resp_d          = RespOkay;
                if (is_write_q) begin
                    for (int b = 0; b < StrbW; b++) begin
                        merged_d[b*8 +: 8] = wstrb_q[b] ? wdata_q[b*8 +: 8] : rd_word[b*8 +: 8];
                    end
                    state_d = StRfWrite;
                end else begin
                    rdata_d = rd_word;
                    state_d = StResp;
                end
            end
            StRfWrite: begin
                cm_regfile_addr = rf_idx;
                cm_regfile_we   = sel_onehot;
                fault_clr       = 1'b1;
                state_d         = StResp;
            end
            StResp: begin
                if (is_write_q ? S_AXI_BREADY : S_AXI_RREADY) begin
                    auto_halt_d = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            is_write_q  <= 1'b0;
            prefer_wr_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            merged_q    <= '0;
            rdata_q     <= '0;
            resp_q      <= RespOkay;
            auto_halt_q <= '0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            prefer_wr_q <= prefer_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            merged_q    <= merged_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            auto_halt_q <= auto_halt_d;
            settle_q    <= settle_d;
        end
    end

`ifdef SOC_CTRL_FAULT_INJ_EN
    assign cm_write_regfile_dat = merged_q ^ fault_mask;
`else
    logic unused_fault_mask;
    assign unused_fault_mask    = ^fault_mask;
    assign cm_write_regfile_dat = merged_q;
`endif

    assign cm_cpu_stop  = halt | auto_halt_q;
    assign S_AXI_RVALID = (state_q == StResp) && !is_write_q;
    assign S_AXI_BVALID = (state_q == StResp) && is_write_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = resp_q;
    assign S_AXI_BRESP  = resp_q;
    assign deb_state    = state_q;

    logic unused_top;
    assign unused_top = ^{S_AXI_AWPROT, S_AXI_ARPROT, addr_q[1:0], acc_addr[1:0]};

endmodule

// File: tb/tb_soc_debug_ctrl.sv
// Scoreboard bench for soc_debug_ctrl with a two-core regfile model.
module tb_soc_debug_ctrl;

    localparam int NC     = 2;
    localparam int SETTLE = 2;
`ifdef SOC_CTRL_FAULT_INJ_EN
    localparam logic [31:0] FaultX3 = 32'h0000_0001;
`else
    localparam logic [31:0] FaultX3 = 32'h0000_0000;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] cm_cpu_stop, cm_regfile_we;
    logic [4:0]    cm_regfile_addr;
    logic [31:0]   cm_write_regfile_dat;
    logic [63:0]   cm_read_regfile_dat;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [7:0]    awaddr, araddr;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [2:0]    deb_state;

    logic [31:0] rf [NC][32];
    logic        ld_en;
    int          ld_core, ld_idx;
    logic [31:0] ld_dat;
    int          cyc = 0;
    int          we_cnt = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        bit          wr;
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    soc_debug_ctrl #(
        .NUM_CORES      (NC),
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .AXI_ADDR_WIDTH (8),
        .STOP_SETTLE    (SETTLE)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cm_cpu_stop          (cm_cpu_stop),
        .cm_regfile_we        (cm_regfile_we),
        .cm_regfile_addr      (cm_regfile_addr),
        .cm_write_regfile_dat (cm_write_regfile_dat),
        .cm_read_regfile_dat  (cm_read_regfile_dat),
        .S_AXI_AWVALID        (awvalid),
        .S_AXI_AWREADY        (awready),
        .S_AXI_AWADDR         (awaddr),
        .S_AXI_AWPROT         (3'b000),
        .S_AXI_WVALID         (wvalid),
        .S_AXI_WREADY         (wready),
        .S_AXI_WDATA          (wdata),
        .S_AXI_WSTRB          (wstrb),
        .S_AXI_BVALID         (bvalid),
        .S_AXI_BREADY         (bready),
        .S_AXI_BRESP          (bresp),
        .S_AXI_ARVALID        (arvalid),
        .S_AXI_ARREADY        (arready),
        .S_AXI_ARADDR         (araddr),
        .S_AXI_ARPROT         (3'b000),
        .S_AXI_RVALID         (rvalid),
        .S_AXI_RREADY         (rready),
        .S_AXI_RDATA          (rdata),
        .S_AXI_RRESP          (rresp),
        .deb_state            (deb_state)
    );

    // Regfile model: combinational read, clocked write, plus a preload port
    assign cm_read_regfile_dat = {rf[1][cm_regfile_addr], rf[0][cm_regfile_addr]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_en) rf[ld_core][ld_idx] <= ld_dat;
        for (int k = 0; k < NC; k++) begin
            if (cm_regfile_we[k]) rf[k][cm_regfile_addr] <= cm_write_regfile_dat;
        end
        if (|cm_regfile_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired or no matching expectation", name);
    endtask

    task automatic check_resp(input bit wr, input logic [1:0] resp, input logic [31:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            note_fail("unexpected_resp");
            return;
        end
        e = sb.pop_front();
        check("resp_kind", 32'(wr), 32'(e.wr));
        check("resp_code", 32'(resp), 32'(e.resp));
        if (!wr) check("rdata", data, e.data);
        if (e.lat >= 0) check("latency", 32'(cyc - e.acc), 32'(e.lat));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid && rready) check_resp(1'b0, rresp, rdata);
            if (bvalid && bready) check_resp(1'b1, bresp, 32'h0);
        end
    end

    task automatic preload(input int k, input int idx, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_core = k; ld_idx = idx; ld_dat = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [1:0] er, input logic [31:0] ed,
                           input int el);
        int n = 0;
        int acc;
        araddr  = a;
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 100) begin @(negedge clk); n++; end
        if (!arready) begin
            note_fail("ar_accept_timeout");
            arvalid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge clk); #1;
        arvalid = 1'b0;
        sb.push_back('{1'b0, er, ed, el, acc});
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er, input int el);
        int n = 0;
        int acc;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 100) begin @(negedge clk); n++; end
        if (!awready) begin
            note_fail("aw_accept_timeout");
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        check("wready_with_awready", 32'(wready), 32'h1);
        acc = cyc;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (el >= -1) sb.push_back('{1'b1, er, 32'h0, el, acc});
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
        if (sb.size() != 0) begin
            note_fail("resp_timeout");
            sb.delete();
        end
        #1;
    endtask

    initial begin
        int n;
        int we0;
        rst_n = 1'b0;
        awvalid = 0; wvalid = 0; arvalid = 0; awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        rready = 1'b1; bready = 1'b1;
        ld_en = 0; ld_core = 0; ld_idx = 0; ld_dat = 0;

        preload(0, 2, 32'h1234_5678);
        preload(0, 5, 32'hAABB_CCDD);
        preload(0, 3, 32'h0000_0055);
        preload(1, 2, 32'hCAFE_F00D);

        // Reset state
        check("rst_stop", 32'(cm_cpu_stop), 32'h0);
        check("rst_we", 32'(cm_regfile_we), 32'h0);
        check("rst_valids", 32'({rvalid, bvalid, arready, awready}), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_resp", 32'({rresp, bresp}), 32'h0);
        check("rst_state", 32'(deb_state), 32'h0);
        check("rst_rf_addr", 32'(cm_regfile_addr), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Auto-halt read of x2
        do_read(8'h88, 2'b00, 32'h1234_5678, SETTLE + 2);
        check("autohalt_stop_rise", 32'(cm_cpu_stop), 32'h1);
        wait_done();
        check("autohalt_stop_fall", 32'(cm_cpu_stop), 32'h0);

        // Strobed RMW write of x5
        we0 = we_cnt;
        do_write(8'h94, 32'h1122_3344, 4'b0101, 2'b00, SETTLE + 3);
        wait_done();
        check("rmw_we_pulses", 32'(we_cnt - we0), 32'h1);
        check("rmw_x5", rf[0][5], 32'hAA22_CC44);

        // Explicit HALT skips HALT_WAIT
        do_write(8'h00, 32'h1, 4'hF, 2'b00, 1);
        wait_done();
        check("halt_stop", 32'(cm_cpu_stop), 32'h1);
        do_read(8'h88, 2'b00, 32'h1234_5678, 2);
        check("halt_no_wait", 32'(deb_state), 32'h2);
        wait_done();
        check("halt_stop_kept", 32'(cm_cpu_stop), 32'h1);
        do_read(8'h08, 2'b00, 32'h1, 1);
        wait_done();
        do_write(8'h00, 32'h0, 4'hF, 2'b00, 1);
        wait_done();
        check("halt_release", 32'(cm_cpu_stop), 32'h0);

        // Fault mask one-shot
        do_write(8'h0C, 32'h1, 4'hF, 2'b00, 1);
        wait_done();
        do_write(8'h8C, 32'h0, 4'hF, 2'b00, SETTLE + 3);
        wait_done();
        check("fault_x3_first", rf[0][3], FaultX3);
        do_read(8'h0C, 2'b00, 32'h0, 1);
        wait_done();
        do_write(8'h8C, 32'h0, 4'hF, 2'b00, SETTLE + 3);
        wait_done();
        check("fault_x3_second", rf[0][3], 32'h0);

        // Core 1 select, then out-of-range core and unmapped CSR
        do_write(8'h04, 32'h1, 4'hF, 2'b00, 1);
        wait_done();
        do_read(8'h88, 2'b00, 32'hCAFE_F00D, SETTLE + 2);
        check("core1_stop", 32'(cm_cpu_stop), 32'h2);
        wait_done();
        do_write(8'h04, 32'h2, 4'hF, 2'b00, 1);
        wait_done();
        do_read(8'h04, 2'b00, 32'h2, 1);
        wait_done();
        we0 = we_cnt;
        do_read(8'h88, 2'b10, 32'h0, 1);
        check("badsel_no_stop", 32'(cm_cpu_stop), 32'h0);
        wait_done();
        do_write(8'h94, 32'hFFFF_FFFF, 4'hF, 2'b10, 1);
        wait_done();
        check("badsel_no_we", 32'(we_cnt - we0), 32'h0);
        do_read(8'h10, 2'b10, 32'h0, 1);
        wait_done();
        do_write(8'h08, 32'hFF, 4'hF, 2'b00, 1);
        wait_done();
        do_write(8'h04, 32'h0, 4'hF, 2'b00, 1);
        wait_done();

        // Reset during HALT_WAIT of a write
        we0 = we_cnt;
        do_write(8'h94, 32'hFFFF_FFFF, 4'hF, 2'b00, -2);
        check("midrst_in_haltwait", 32'(deb_state), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_stop", 32'(cm_cpu_stop), 32'h0);
        check("midrst_state", 32'(deb_state), 32'h0);
        check("midrst_bvalid", 32'(bvalid), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_we", 32'(we_cnt - we0), 32'h0);
        check("midrst_x5", rf[0][5], 32'hAA22_CC44);

        // Read and write eligible together after reset: read first
        araddr = 8'h88; arvalid = 1'b1;
        awaddr = 8'h8C; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("arb_read_first", 32'({arready, awready}), 32'h2);
        n = cyc;
        @(posedge clk); #1;
        arvalid = 1'b0;
        sb.push_back('{1'b0, 2'b00, 32'h1234_5678, SETTLE + 2, n});
        do_write(8'h8C, 32'hDEAD_BEEF, 4'hF, 2'b00, SETTLE + 3);
        wait_done();
        check("arb_write_x3", rf[0][3], 32'hDEAD_BEEF);

        // AW without W does not block a read
        awaddr = 8'h00; awvalid = 1'b1;
        do_read(8'h04, 2'b00, 32'h0, 1);
        wait_done();
        awvalid = 1'b0;

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
